writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Producer side of the register file write port.
- Merges ALU results and late-returning load results into the single regfile write port (write enable, rd address, rd data).
- Buffers load results in a small in-order queue.
- Resolves write-after-write ordering between the two sources.
- Gives decode a bypass view of writes not yet committed to the regfile.

Parameters:
DATA_W, 32, width of result data and regfile data
ADDR_W, 5, register address width
LQ_DEPTH, 4, load queue entries (power of two, >=2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result offered
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted this cycle (combinational)
ld_valid  in  1  load result offered
ld_rd  in  ADDR_W  load destination register
ld_data  in  DATA_W  load result
ld_ready  out  1  load result accepted this cycle (combinational)
rf_write_enable  out  1  regfile write enable (registered)
rf_addr_rd  out  ADDR_W  regfile write address (registered)
rf_data_rd  out  DATA_W  regfile write data (registered)
byp_addr_rs1  in  ADDR_W  bypass query address, port 1
byp_addr_rs2  in  ADDR_W  bypass query address, port 2
byp_hit_rs1  out  1  pending write to byp_addr_rs1 exists
byp_data_rs1  out  DATA_W  youngest pending value for byp_addr_rs1
byp_hit_rs2  out  1  pending write to byp_addr_rs2 exists
byp_data_rs2  out  DATA_W  youngest pending value for byp_addr_rs2
lq_count  out  clog2(LQ_DEPTH)+1  load queue occupancy

Behaviour:
- Reset (async, immediate): queue emptied (pointers and count 0); rf_write_enable=0, rf_addr_rd=0, rf_data_rd=0; byp_hit_*=0. Reset mid-operation discards every pending write. No write reaches the regfile after reset asserts.
- Handshake: transfer occurs when valid && ready in the same cycle. Producers hold rd/data stable while valid && !ready.
- Load queue enqueue:
  - ld_ready = (lq_count != LQ_DEPTH).
  - Accepted loads are appended in arrival order.
  - Enqueue and dequeue in the same cycle leave lq_count unchanged.
  - No enqueue when full, even if a dequeue occurs in that cycle.
- Write-port arbitration, one winner per cycle:
  - Queue head wins when the queue is full.
  - Queue head wins when alu_valid and any queue entry has rd == alu_rd with alu_rd != 0 (WAW block). alu_ready=0 in that case.
  - Otherwise an ALU result wins if alu_valid; alu_ready=1.
  - Otherwise the queue head is dequeued if the queue is non-empty.
  - alu_ready=0 whenever the queue head wins.
- Output stage:
  - The winner is registered into rf_addr_rd/rf_data_rd.
  - rf_write_enable=1 on the next edge, so latency from accept to regfile write is 1 cycle; regfile update lands on the following edge.
  - rf_write_enable=0 in any cycle with no winner.
- x0: a winner with rd=0 is consumed (handshake completes, entry dequeued) but produces rf_write_enable=0.
- Bypass, combinational, per port:
  - Candidates are all valid queue entries plus the output stage when rf_write_enable=1.
  - Youngest match wins: the newest queue entry, else the output stage.
  - Query address 0 never hits; byp_data=0 when there is no hit.
  - A result offered on the ALU or load port this cycle is not a candidate.
- Width rules: pointers wrap modulo LQ_DEPTH; lq_count ranges 0..LQ_DEPTH.

Decomposition:
- Package wb_pkg: DATA_W/ADDR_W defaults, REG_ZERO constant, wb_entry_t struct {rd, data}.
- Sub-module wb_load_fifo:
  - Circular queue with head/tail/count.
  - Exposes head entry, full/empty, and a flattened entry array with valid bits for the WAW and bypass comparators.

Test Plan:
- Reset, then alu_valid with rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle rf_write_enable=1, rf_addr_rd=5, rf_data_rd=0xDEADBEEF; the cycle after, rf_write_enable=0.
- Hold alu_valid (rd=1..) every cycle while offering 4 loads rd=10..13 -> queue fills, lq_count=4, ld_ready=0. Then alu_ready=0 for the cycle head rd=10 is written, ld_ready returns to 1, and loads drain in order 10,11,12,13.
- Load rd=7 queued, then ALU rd=7 offered -> alu_ready=0 until the load commits (rf_addr_rd=7 with the load data). The ALU write follows on the next cycle, so the regfile ends with the ALU value.
- ALU rd=0, data=0x1234 -> alu_ready=1; rf_write_enable stays 0. Query byp_addr_rs1=0 -> byp_hit_rs1=0.
- Queue loads rd=3 (0x11) then rd=3 (0x22); query rs1=3 -> byp_hit_rs1=1, byp_data_rs1=0x22. Query rs2=4 -> byp_hit_rs2=0.
- Queue 3 loads, assert reset mid-cycle -> lq_count=0, rf_write_enable=0 immediately. After release, no stale writes appear and ld_ready=1.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared defaults and types for the writeback unit
package wb_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_LQ_DEPTH = 4;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - in-order load result queue with age-ordered entry view
module wb_load_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enq,
  input  logic [ADDR_W-1:0]          enq_rd,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       deq,
  output logic [ADDR_W-1:0]          head_rd,
  output logic [DATA_W-1:0]          head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH*ADDR_W-1:0]    ent_rd_flat,
  output logic [DEPTH*DATA_W-1:0]    ent_data_flat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] mem_rd_q [DEPTH];
  logic [ADDR_W-1:0] mem_rd_d [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic              enq_ok, deq_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign enq_ok  = enq && !full;
  assign deq_ok  = deq && !empty;
  assign count   = count_q;
  assign head_rd   = mem_rd_q[head_q];
  assign head_data = mem_data_q[head_q];

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (enq_ok) begin
      mem_rd_d[tail_q]   = enq_rd;
      mem_data_d[tail_q] = enq_data;
      tail_d             = tail_q + PW'(1);
    end
    if (deq_ok) begin
      head_d = head_q + PW'(1);
    end
    case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Slot g is the g-th oldest entry, so the highest valid slot is the youngest.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] idx;
    assign idx                             = head_q + PW'(g);
    assign ent_valid[g]                    = (CW'(g) < count_q);
    assign ent_rd_flat[g*ADDR_W +: ADDR_W] = mem_rd_q[idx];
    assign ent_data_flat[g*DATA_W +: DATA_W] = mem_data_q[idx];
  end
endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - arbitrates ALU and load results onto the regfile write port
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LQ_DEPTH = DEF_LQ_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [ADDR_W-1:0]           alu_rd,
  input  logic [DATA_W-1:0]           alu_data,
  output logic                        alu_ready,
  input  logic                        ld_valid,
  input  logic [ADDR_W-1:0]           ld_rd,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        ld_ready,
  output logic                        rf_write_enable,
  output logic [ADDR_W-1:0]           rf_addr_rd,
  output logic [DATA_W-1:0]           rf_data_rd,
  input  logic [ADDR_W-1:0]           byp_addr_rs1,
  input  logic [ADDR_W-1:0]           byp_addr_rs2,
  output logic                        byp_hit_rs1,
  output logic [DATA_W-1:0]           byp_data_rs1,
  output logic                        byp_hit_rs2,
  output logic [DATA_W-1:0]           byp_data_rs2,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);
  localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

  logic [ADDR_W-1:0]          lq_head_rd;
  logic [DATA_W-1:0]          lq_head_data;
  logic                       lq_full, lq_empty, lq_enq, lq_deq;
  logic [LQ_DEPTH-1:0]        lq_valid;
  logic [LQ_DEPTH*ADDR_W-1:0] lq_rd_flat;
  logic [LQ_DEPTH*DATA_W-1:0] lq_data_flat;

  logic                       waw_hit, head_win, win_valid;
  logic [ADDR_W-1:0]          win_rd;
  logic [DATA_W-1:0]          win_data;
  logic                       rf_write_enable_q, rf_write_enable_d;
  logic [ADDR_W-1:0]          rf_addr_rd_q, rf_addr_rd_d;
  logic [DATA_W-1:0]          rf_data_rd_q, rf_data_rd_d;

  wb_load_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (LQ_DEPTH)
  ) u_lq (
    .clock         (clock),
    .reset         (reset),
    .enq           (lq_enq),
    .enq_rd        (ld_rd),
    .enq_data      (ld_data),
    .deq           (lq_deq),
    .head_rd       (lq_head_rd),
    .head_data     (lq_head_data),
    .full          (lq_full),
    .empty         (lq_empty),
    .count         (lq_count),
    .ent_valid     (lq_valid),
    .ent_rd_flat   (lq_rd_flat),
    .ent_data_flat (lq_data_flat)
  );

  // An ALU write may not overtake an older queued load to the same register.
  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_valid[i] && (lq_rd_flat[i*ADDR_W +: ADDR_W] == alu_rd)) begin
        waw_hit = 1'b1;
      end
    end
  end

  assign head_win  = !lq_empty &&
                     (lq_full || !alu_valid || (waw_hit && (alu_rd != RZ)));
  assign alu_ready = alu_valid && !head_win;
  assign ld_ready  = !lq_full;
  assign lq_enq    = ld_valid && !lq_full;
  assign lq_deq    = head_win;
  assign win_valid = head_win || alu_ready;
  assign win_rd    = head_win ? lq_head_rd   : alu_rd;
  assign win_data  = head_win ? lq_head_data : alu_data;

  always_comb begin
    rf_write_enable_d = win_valid && (win_rd != RZ);
    rf_addr_rd_d      = rf_addr_rd_q;
    rf_data_rd_d      = rf_data_rd_q;
    if (win_valid) begin
      rf_addr_rd_d = win_rd;
      rf_data_rd_d = win_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_write_enable_q <= 1'b0;
      rf_addr_rd_q      <= '0;
      rf_data_rd_q      <= '0;
    end else begin
      rf_write_enable_q <= rf_write_enable_d;
      rf_addr_rd_q      <= rf_addr_rd_d;
      rf_data_rd_q      <= rf_data_rd_d;
    end
  end

  assign rf_write_enable = rf_write_enable_q;
  assign rf_addr_rd      = rf_addr_rd_q;
  assign rf_data_rd      = rf_data_rd_q;

  logic [ADDR_W-1:0] byp_q    [2];
  logic [1:0]        byp_hit;
  logic [DATA_W-1:0] byp_data [2];

  assign byp_q[0] = byp_addr_rs1;
  assign byp_q[1] = byp_addr_rs2;

  // Output stage is the oldest candidate; later queue slots override it.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      byp_hit[p]  = 1'b0;
      byp_data[p] = '0;
      if (byp_q[p] != RZ) begin
        if (rf_write_enable_q && (rf_addr_rd_q == byp_q[p])) begin
          byp_hit[p]  = 1'b1;
          byp_data[p] = rf_data_rd_q;
        end
        for (int i = 0; i < LQ_DEPTH; i++) begin
          if (lq_valid[i] && (lq_rd_flat[i*ADDR_W +: ADDR_W] == byp_q[p])) begin
            byp_hit[p]  = 1'b1;
            byp_data[p] = lq_data_flat[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign byp_hit_rs1  = byp_hit[0];
  assign byp_data_rs1 = byp_data[0];
  assign byp_hit_rs2  = byp_hit[1];
  assign byp_data_rs2 = byp_data[1];
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - scoreboard bench for writeback_unit
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid;
  logic [AW-1:0] alu_rd, ld_rd, byp_addr_rs1, byp_addr_rs2;
  logic [DW-1:0] alu_data, ld_data;
  logic          alu_ready, ld_ready, rf_write_enable, byp_hit_rs1, byp_hit_rs2;
  logic [AW-1:0] rf_addr_rd;
  logic [DW-1:0] rf_data_rd, byp_data_rs1, byp_data_rs2;
  logic [2:0]    lq_count;

  always #5 clock = ~clock;

  writeback_unit #(.DATA_W(DW), .ADDR_W(AW), .LQ_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_write_enable(rf_write_enable), .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd),
    .byp_addr_rs1(byp_addr_rs1), .byp_addr_rs2(byp_addr_rs2),
    .byp_hit_rs1(byp_hit_rs1), .byp_data_rs1(byp_data_rs1),
    .byp_hit_rs2(byp_hit_rs2), .byp_data_rs2(byp_data_rs2),
    .lq_count(lq_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: pending loads in arrival order, the write visible on the
  // port this cycle, and the writes the regfile port still owes us.
  wb_entry_t mq[$];
  wb_entry_t expq[$];
  bit        os_v;
  wb_entry_t os;
  bit        alu_acc, ld_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void byp_ref(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
    hit = 0;
    d   = '0;
    if (a != 0) begin
      if (os_v && os.rd == a) begin hit = 1; d = os.data; end
      foreach (mq[i]) if (mq[i].rd == a) begin hit = 1; d = mq[i].data; end
    end
  endfunction

  // One clock: compare combinational outputs, advance the model, cross the edge.
  task automatic step();
    bit full, nonempty, match, waw, head_win, wv, h;
    logic [DW-1:0] d;
    wb_entry_t w, e;
    #1;
    full     = (mq.size() == D);
    nonempty = (mq.size() != 0);
    match    = 0;
    foreach (mq[i]) if (mq[i].rd == alu_rd) match = 1;
    waw      = alu_valid && alu_rd != 0 && match;
    head_win = nonempty && (full || waw || !alu_valid);
    alu_acc  = alu_valid && !head_win;
    ld_acc   = ld_valid && !full;
    chk("alu_ready", alu_ready, alu_acc);
    chk("ld_ready", ld_ready, !full);
    chk("lq_count", lq_count, mq.size());
    byp_ref(byp_addr_rs1, h, d);
    chk("byp_hit_rs1", byp_hit_rs1, h);
    chk("byp_data_rs1", byp_data_rs1, d);
    byp_ref(byp_addr_rs2, h, d);
    chk("byp_hit_rs2", byp_hit_rs2, h);
    chk("byp_data_rs2", byp_data_rs2, d);
    wv = 0;
    w  = '0;
    if (head_win) begin
      w = mq.pop_front(); wv = 1;
    end else if (alu_valid) begin
      w.rd = alu_rd; w.data = alu_data; wv = 1;
    end
    if (ld_acc) begin
      e.rd = ld_rd; e.data = ld_data; mq.push_back(e);
    end
    os_v = wv && w.rd != 0;
    os   = w;
    if (os_v) expq.push_back(w);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic offer(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] adata,
                       input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldata);
    int n = 0;
    alu_valid = av; alu_rd = ard; alu_data = adata;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldata;
    while ((alu_valid || ld_valid) && n < 20) begin
      step();
      if (alu_acc) alu_valid = 0;
      if (ld_acc)  ld_valid  = 0;
      n++;
    end
    checks++;
    if (alu_valid || ld_valid) begin
      errors++;
      $display("FAIL offer_timeout: got pending alu=%0d ld=%0d required none", alu_valid, ld_valid);
      alu_valid = 0;
      ld_valid  = 0;
    end
  endtask

  task automatic idle(input int n);
    alu_valid = 0;
    ld_valid  = 0;
    repeat (n) step();
  endtask

  task automatic do_reset_mid();
    #2 reset = 1;
    #1;
    chk("reset_we_now", rf_write_enable, 0);
    chk("reset_lq_now", lq_count, 0);
    mq.delete();
    expq.delete();
    os_v = 0;
    alu_valid = 0;
    ld_valid  = 0;
    @(negedge clock);
    reset = 0;
  endtask

  // Every registered write must be the next one the model owes.
  always @(negedge clock) begin
    if (reset === 1'b0 && rf_write_enable === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h required no write", rf_addr_rd, rf_data_rd);
      end else begin
        wb_entry_t e;
        e = expq.pop_front();
        chk("rf_addr_rd", rf_addr_rd, e.rd);
        chk("rf_data_rd", rf_data_rd, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
    byp_addr_rs1 = 5; byp_addr_rs2 = 0;
    os_v = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_we", rf_write_enable, 0);
    chk("rst_addr", rf_addr_rd, 0);
    chk("rst_data", rf_data_rd, 0);
    chk("rst_lq", lq_count, 0);
    chk("rst_hit1", byp_hit_rs1, 0);
    chk("rst_hit2", byp_hit_rs2, 0);
    reset = 0;

    // Single ALU write.
    offer(1, 5, 32'hDEADBEEF, 0, 0, 0);
    idle(2);

    // Queue fills behind a busy ALU, then drains in order.
    for (int i = 0; i < 4; i++) offer(1, AW'(i + 1), $urandom, 1, AW'(10 + i), 32'hA000 + i);
    offer(1, 5, 32'h5555, 1, 14, 32'hA004);
    idle(8);

    // WAW: the queued load to r7 commits before the ALU write to r7.
    offer(1, 15, 32'h1515, 1, 7, 32'h7777);
    offer(1, 7, 32'hA1A1, 0, 0, 0);
    idle(3);

    // x0 is consumed without a write and never bypasses.
    byp_addr_rs1 = 0;
    offer(1, 0, 32'h1234, 0, 0, 0);
    idle(2);

    // Two queued loads to r3: youngest value bypasses.
    byp_addr_rs1 = 3; byp_addr_rs2 = 4;
    offer(1, 20, 32'h2020, 1, 3, 32'h11);
    offer(1, 21, 32'h2121, 1, 3, 32'h22);
    offer(1, 22, 32'h2222, 0, 0, 0);
    idle(4);

    // Reset with three loads in flight drops them all.
    offer(1, 23, 32'h23, 1, 8, 32'h88);
    offer(1, 24, 32'h24, 1, 9, 32'h99);
    offer(1, 25, 32'h25, 1, 10, 32'hAA);
    alu_valid = 1; alu_rd = 26; alu_data = 32'h26;
    do_reset_mid();
    idle(4);

    // Randomized traffic with a small register range to provoke hazards.
    for (int c = 0; c < 500; c++) begin
      if (!alu_valid && $urandom_range(0, 3) != 0) begin
        alu_valid = 1; alu_rd = AW'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!ld_valid && $urandom_range(0, 2) == 0) begin
        ld_valid = 1; ld_rd = AW'($urandom_range(0, 7)); ld_data = $urandom;
      end
      byp_addr_rs1 = AW'($urandom_range(0, 7));
      byp_addr_rs2 = AW'($urandom_range(0, 7));
      step();
      if (alu_acc) alu_valid = 0;
      if (ld_acc)  ld_valid  = 0;
    end
    n = 0;
    while ((alu_valid || ld_valid) && n < 20) begin
      step();
      if (alu_acc) alu_valid = 0;
      if (ld_acc)  ld_valid  = 0;
      n++;
    end
    alu_valid = 0;
    ld_valid  = 0;
    n = 0;
    while (mq.size() != 0 && n < 20) begin
      step();
      n++;
    end
    idle(2);
    chk("drain_expq", expq.size(), 0);
    chk("drain_lq", lq_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
